// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 7-segment digit scan controller.
package mux_scan_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // First enabled digit after cur (cur+1, cur+2, cur+3, then cur); holds cur if mask is empty.
    function automatic logic [SEL_W-1:0] next_digit(
        input logic [SEL_W-1:0]    cur,
        input logic [N_DIGITS-1:0] mask
    );
        logic [SEL_W-1:0] nxt;
        logic [SEL_W-1:0] cand;
        nxt = cur;
        // Walk from the farthest candidate down so the nearest enabled one wins.
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            cand = cur + SEL_W'(k);
            if (mask[cand]) begin
                nxt = cand;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Refresh prescaler: counts clk cycles within a digit slot and flags the last one.
module scan_prescaler #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] pcnt,
    output logic             slot_tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;

    // Last cycle of the slot, only while scanning.
    assign slot_tick = en && (pcnt_q == TERM);
    assign pcnt      = pcnt_q;

    // Wrap at the terminal count; freeze while disabled.
    always_comb begin
        pcnt_d = pcnt_q;
        if (en) begin
            pcnt_d = (pcnt_q == TERM) ? '0 : pcnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Digit scan sequencer for a 4-digit multiplexed 7-segment display.
// Drives the mux select and active-low anodes, blanking at each digit change.
// Optional build macro MUX_SCAN_DIM_EN adds a 2-bit per-slot brightness input `dim`.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_DIGITS-1:0] dig_mask,
`ifdef MUX_SCAN_DIM_EN
    input  logic [1:0]          dim,
`endif
    output logic [SEL_W-1:0]    sel,
    output logic [N_DIGITS-1:0] anode_n,
    output logic                slot_tick
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0]    pcnt;
    scan_state_e         state_q,   state_d;
    logic [CNT_W-1:0]    bcnt_q,    bcnt_d;
    logic [SEL_W-1:0]    sel_q,     sel_d;
    logic [N_DIGITS-1:0] anode_n_q, anode_n_d;
    logic                duty_ok;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pcnt      (pcnt),
        .slot_tick (slot_tick)
    );

`ifdef MUX_SCAN_DIM_EN
    localparam int unsigned TW   = CNT_W + 3;
    localparam int unsigned SPAN = CLK_DIV - BLANK_CYCLES;

    logic [1:0]    dim_q, dim_d;
    logic [TW-1:0] on_limit;

    // Brightness is latched at the slot boundary; anode lit while the next pcnt is below the limit.
    always_comb begin
        dim_d    = slot_tick ? dim : dim_q;
        on_limit = TW'(BLANK_CYCLES) + ((TW'(SPAN) * (TW'(dim_q) + TW'(1))) >> 2);
        duty_ok  = (TW'(pcnt) + TW'(1)) < on_limit;
    end

    // Brightness register, full duty out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q <= 2'b11;
        end else begin
            dim_q <= dim_d;
        end
    end
`else
    logic unused_pcnt;

    // Without dimming the digit stays lit for the rest of the slot.
    assign duty_ok     = 1'b1;
    assign unused_pcnt = ^pcnt;
`endif

    // Next state, blanking counter, digit advance and anode decode.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        sel_d     = sel_q;
        anode_n_d = '1;

        if (!en) begin
            state_d = BLANK;
            bcnt_d  = '0;
        end else if (slot_tick) begin
            state_d = BLANK;
            bcnt_d  = '0;
            sel_d   = next_digit(sel_q, dig_mask);
        end else if (state_q == BLANK) begin
            if (bcnt_q == BLANK_LAST) begin
                state_d = SHOW;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q + CNT_W'(1);
            end
        end

        // sel never changes on an edge that enters or stays in SHOW, so sel_q is the lit digit.
        if ((state_d == SHOW) && dig_mask[sel_q] && duty_ok) begin
            anode_n_d[sel_q] = 1'b0;
        end
    end

    // State, select and anode registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            bcnt_q    <= '0;
            sel_q     <= '0;
            anode_n_q <= '1;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            sel_q     <= sel_d;
            anode_n_q <= anode_n_d;
        end
    end

    assign sel     = sel_q;
    assign anode_n = anode_n_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with an 8-cycle slot and 2 blank cycles.
module tb_mux_scan_ctrl;

    localparam int unsigned CLK_DIV      = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned CNT_W        = 4;
    localparam int          NV           = 39;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] dig_mask;
    logic [1:0] sel;
    logic [3:0] anode_n;
    logic       slot_tick;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         adv;
        logic       rst_n;
        logic       en;
        logic [3:0] mask;
        logic [1:0] sel;
        logic [3:0] an;
        logic       tick;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    mux_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .dig_mask  (dig_mask),
        .sel       (sel),
        .anode_n   (anode_n),
        .slot_tick (slot_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] es, input logic [3:0] ea, input logic et);
        chk({tag, " sel"},       32'(sel),       32'(es));
        chk({tag, " anode_n"},   32'(anode_n),   32'(ea));
        chk({tag, " slot_tick"}, 32'(slot_tick), 32'(et));
    endtask

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int adv, input logic r, input logic e, input logic [3:0] m,
                                input logic [1:0] s, input logic [3:0] a, input logic t);
        vec_t v;
        v.adv = adv; v.rst_n = r; v.en = e; v.mask = m;
        v.sel = s; v.an = a; v.tick = t;
        return v;
    endfunction

    initial begin
        logic [1:0] es;
        logic [3:0] ea;
        logic       et;

        // mask 0101: digits 0 and 2 only
        vecs[0]  = mk(0, 1'b0, 1'b1, 4'h5, 2'd0, 4'hF, 1'b0);
        vecs[1]  = mk(0, 1'b1, 1'b1, 4'h5, 2'd0, 4'hF, 1'b0);
        vecs[2]  = mk(2, 1'b1, 1'b1, 4'h5, 2'd0, 4'hE, 1'b0);
        vecs[3]  = mk(5, 1'b1, 1'b1, 4'h5, 2'd0, 4'hE, 1'b1);
        vecs[4]  = mk(1, 1'b1, 1'b1, 4'h5, 2'd2, 4'hF, 1'b0);
        vecs[5]  = mk(1, 1'b1, 1'b1, 4'h5, 2'd2, 4'hF, 1'b0);
        vecs[6]  = mk(1, 1'b1, 1'b1, 4'h5, 2'd2, 4'hB, 1'b0);
        vecs[7]  = mk(6, 1'b1, 1'b1, 4'h5, 2'd0, 4'hF, 1'b0);
        vecs[8]  = mk(2, 1'b1, 1'b1, 4'h5, 2'd0, 4'hE, 1'b0);
        // empty mask: sel holds, anodes dark, tick keeps pulsing
        vecs[9]  = mk(0, 1'b0, 1'b1, 4'h0, 2'd0, 4'hF, 1'b0);
        vecs[10] = mk(0, 1'b1, 1'b1, 4'h0, 2'd0, 4'hF, 1'b0);
        vecs[11] = mk(2, 1'b1, 1'b1, 4'h0, 2'd0, 4'hF, 1'b0);
        vecs[12] = mk(5, 1'b1, 1'b1, 4'h0, 2'd0, 4'hF, 1'b1);
        vecs[13] = mk(8, 1'b1, 1'b1, 4'h0, 2'd0, 4'hF, 1'b1);
        vecs[14] = mk(1, 1'b1, 1'b1, 4'h0, 2'd0, 4'hF, 1'b0);
        // mask edits: clear mid-SHOW, change during tick, set mid-slot
        vecs[15] = mk(0, 1'b0, 1'b1, 4'hF, 2'd0, 4'hF, 1'b0);
        vecs[16] = mk(3, 1'b1, 1'b1, 4'hF, 2'd0, 4'hE, 1'b0);
        vecs[17] = mk(1, 1'b1, 1'b1, 4'hE, 2'd0, 4'hF, 1'b0);
        vecs[18] = mk(3, 1'b1, 1'b1, 4'hE, 2'd0, 4'hF, 1'b1);
        vecs[19] = mk(1, 1'b1, 1'b1, 4'h8, 2'd3, 4'hF, 1'b0);
        vecs[20] = mk(2, 1'b1, 1'b1, 4'h8, 2'd3, 4'h7, 1'b0);
        vecs[21] = mk(1, 1'b1, 1'b1, 4'h9, 2'd3, 4'h7, 1'b0);
        vecs[22] = mk(5, 1'b1, 1'b1, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[23] = mk(2, 1'b1, 1'b1, 4'h9, 2'd0, 4'hE, 1'b0);
        // en low at pcnt=5 for 10 cycles, then resume with fresh blanking
        vecs[24] = mk(3, 1'b1, 1'b1, 4'h9, 2'd0, 4'hE, 1'b0);
        vecs[25] = mk(0, 1'b1, 1'b0, 4'h9, 2'd0, 4'hE, 1'b0);
        vecs[26] = mk(1, 1'b1, 1'b0, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[27] = mk(9, 1'b1, 1'b0, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[28] = mk(0, 1'b1, 1'b1, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[29] = mk(1, 1'b1, 1'b1, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[30] = mk(1, 1'b1, 1'b1, 4'h9, 2'd0, 4'hE, 1'b1);
        vecs[31] = mk(1, 1'b1, 1'b1, 4'h9, 2'd3, 4'hF, 1'b0);
        vecs[32] = mk(2, 1'b1, 1'b1, 4'h9, 2'd3, 4'h7, 1'b0);
        // en low during the tick cycle suppresses the tick and the advance
        vecs[33] = mk(5, 1'b1, 1'b1, 4'h9, 2'd3, 4'h7, 1'b1);
        vecs[34] = mk(0, 1'b1, 1'b0, 4'h9, 2'd3, 4'h7, 1'b0);
        vecs[35] = mk(3, 1'b1, 1'b0, 4'h9, 2'd3, 4'hF, 1'b0);
        vecs[36] = mk(0, 1'b1, 1'b1, 4'h9, 2'd3, 4'hF, 1'b1);
        vecs[37] = mk(1, 1'b1, 1'b1, 4'h9, 2'd0, 4'hF, 1'b0);
        vecs[38] = mk(2, 1'b1, 1'b1, 4'h9, 2'd0, 4'hE, 1'b0);

        rst_n    = 1'b0;
        en       = 1'b1;
        dig_mask = 4'hF;
        repeat (2) @(negedge clk);
        chk_all("reset", 2'd0, 4'hF, 1'b0);

        // Free run with all digits: sel steps every slot, 2 blank cycles then the digit's anode.
        rst_n = 1'b1;
        #1;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) step(1);
            es = 2'((n / 8) % 4);
            ea = ((n % 8) >= 2) ? ~(4'b0001 << es) : 4'hF;
            et = ((n % 8) == 7);
            chk_all($sformatf("run n=%0d", n), es, ea, et);
        end

        for (int i = 0; i < NV; i++) begin
            rst_n    = vecs[i].rst_n;
            en       = vecs[i].en;
            dig_mask = vecs[i].mask;
            if (vecs[i].adv == 0) #1;
            else step(vecs[i].adv);
            chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].an, vecs[i].tick);
        end

        // Asynchronous reset while digit 3 is lit, away from any clock edge.
        step(6);
        chk_all("pre-rst slot", 2'd3, 4'hF, 1'b0);
        step(3);
        chk_all("pre-rst show", 2'd3, 4'h7, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 2'd0, 4'hF, 1'b0);
        dig_mask = 4'hF;
        @(negedge clk);
        chk_all("rst held", 2'd0, 4'hF, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_all("post-rst n0", 2'd0, 4'hF, 1'b0);
        step(2);
        chk_all("post-rst n2", 2'd0, 4'hE, 1'b0);
        step(6);
        chk_all("post-rst n8", 2'd1, 4'hF, 1'b0);
        step(2);
        chk_all("post-rst n10", 2'd1, 4'hD, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
